// File: rtl/aes_sbox_sched.sv
// Shares one 32-bit AES S-box between round SubBytes and key SubWord.
// Define AES_SBOX_SCHED_RR_EN for round-robin conflict resolution.
module aes_sbox_sched #(
  parameter int RND_SIZE = 128,
  parameter int WRD_SIZE = 32,
  parameter int NUM_BLK  = 4,
  parameter int CNT_SIZE = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_rnd_vld,
  output logic                o_rnd_rdy,
  input  logic [RND_SIZE-1:0] i_rnd_text,
  output logic [RND_SIZE-1:0] o_rnd_sub,
  output logic                o_rnd_done,
  input  logic                i_key_vld,
  output logic                o_key_rdy,
  input  logic [WRD_SIZE-1:0] i_key_wrd,
  output logic [WRD_SIZE-1:0] o_key_sub,
  output logic                o_key_done,
  output logic [WRD_SIZE-1:0] o_wrd_sbox,
  input  logic [WRD_SIZE-1:0] i_wrd_sbox,
  output logic                o_busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_KEY,
    S_RND
  } state_t;

  localparam logic [CNT_SIZE-1:0] LAST =
    CNT_SIZE'(NUM_BLK - 1);

  state_t              r_state;
  state_t              w_nxt;
  logic [CNT_SIZE-1:0] r_cnt;
  logic [WRD_SIZE-1:0] r_key_cap;
  logic [RND_SIZE-1:0] r_rnd_cap;
  logic [RND_SIZE-1:0] r_rnd_acc;
  logic [RND_SIZE-1:0] r_rnd_sub;
  logic [WRD_SIZE-1:0] r_key_sub;
  logic                r_rnd_done;
  logic                r_key_done;
  logic                w_idle;
  logic                w_key_pri;
  logic                w_gnt_key;
  logic                w_gnt_rnd;
  logic                w_last;
  logic [WRD_SIZE-1:0] w_rnd_wrd;
  logic [RND_SIZE-1:0] w_acc_nxt;

  assign w_idle    = (r_state == S_IDLE);
  assign o_rnd_rdy = w_idle & ~i_rst;
  assign o_key_rdy = w_idle & ~i_rst;
  assign o_busy    = ~w_idle;

`ifdef AES_SBOX_SCHED_RR_EN
  // 1 = key was granted last; reset to round so key wins first
  logic r_last_key;

  assign w_key_pri = ~r_last_key;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_key <= 1'b0;
    end else if (w_gnt_key) begin
      r_last_key <= 1'b1;
    end else if (w_gnt_rnd) begin
      r_last_key <= 1'b0;
    end
  end
`else
  assign w_key_pri = 1'b1;
`endif

  assign w_gnt_key = o_key_rdy & i_key_vld &
                     (~i_rnd_vld | w_key_pri);
  assign w_gnt_rnd = o_rnd_rdy & i_rnd_vld &
                     ~w_gnt_key;

  assign w_last = (r_cnt == LAST);

  // word 0 sits in the top bits of the state
  assign w_rnd_wrd = r_rnd_cap[
    RND_SIZE - 1 - int'(r_cnt) * WRD_SIZE -: WRD_SIZE];

  assign w_acc_nxt = {
    r_rnd_acc[RND_SIZE-WRD_SIZE-1:0], i_wrd_sbox};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  always_comb begin
    w_nxt      = r_state;
    o_wrd_sbox = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_gnt_key) begin
          w_nxt = S_KEY;
        end else if (w_gnt_rnd) begin
          w_nxt = S_RND;
        end
      end
      S_KEY: begin
        o_wrd_sbox = r_key_cap;
        w_nxt      = S_IDLE;
      end
      S_RND: begin
        o_wrd_sbox = w_rnd_wrd;
        if (w_last) begin
          w_nxt = S_IDLE;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt      <= '0;
      r_key_cap  <= '0;
      r_rnd_cap  <= '0;
      r_rnd_acc  <= '0;
      r_rnd_sub  <= '0;
      r_key_sub  <= '0;
      r_rnd_done <= 1'b0;
      r_key_done <= 1'b0;
    end else begin
      r_rnd_done <= 1'b0;
      r_key_done <= 1'b0;
      if (w_gnt_key) begin
        r_key_cap <= i_key_wrd;
      end
      if (w_gnt_rnd) begin
        r_rnd_cap <= i_rnd_text;
        r_cnt     <= '0;
      end
      if (r_state == S_KEY) begin
        r_key_sub  <= i_wrd_sbox;
        r_key_done <= 1'b1;
      end
      // result becomes visible only once all words are in
      if (r_state == S_RND) begin
        r_rnd_acc <= w_acc_nxt;
        r_cnt     <= r_cnt + 1'b1;
        if (w_last) begin
          r_rnd_sub  <= w_acc_nxt;
          r_rnd_done <= 1'b1;
        end
      end
    end
  end

  assign o_rnd_sub  = r_rnd_sub;
  assign o_key_sub  = r_key_sub;
  assign o_rnd_done = r_rnd_done;
  assign o_key_done = r_key_done;

endmodule

// File: tb/tb_aes_sbox_sched.sv
// Bench for aes_sbox_sched with a behavioural S-box on the shared port.
// Scoreboard queues hold expected results until the done pulses.
module tb_aes_sbox_sched;

  localparam logic [127:0] TXT =
    128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] SUB =
    128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [31:0] KW  = 32'hcf4f3c09;
  localparam logic [31:0] KS  = 32'h8a84eb01;

  logic         clk = 1'b0;
  logic         rst;
  logic         rnd_vld;
  logic         rnd_rdy;
  logic [127:0] rnd_text;
  logic [127:0] rnd_sub;
  logic         rnd_done;
  logic         key_vld;
  logic         key_rdy;
  logic [31:0]  key_wrd;
  logic [31:0]  key_sub;
  logic         key_done;
  logic [31:0]  wrd_out;
  logic [31:0]  wrd_in;
  logic         busy;

  int checks = 0;
  int errors = 0;
  bit tb_last = 1'b0;

  logic [127:0] q_rnd[$];
  logic [31:0]  q_key[$];

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(
    input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic       hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [7:0] r, base, s;
    int e;
    r = 8'h01; base = x; e = 254;
    while (e != 0) begin
      if (e[0]) r = gmul(r, base);
      base = gmul(base, base);
      e = e >> 1;
    end
    s = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^
        {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    return s;
  endfunction

  assign wrd_in = {sb(wrd_out[31:24]), sb(wrd_out[23:16]),
                   sb(wrd_out[15:8]),  sb(wrd_out[7:0])};

  aes_sbox_sched dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rnd_vld  (rnd_vld),
    .o_rnd_rdy  (rnd_rdy),
    .i_rnd_text (rnd_text),
    .o_rnd_sub  (rnd_sub),
    .o_rnd_done (rnd_done),
    .i_key_vld  (key_vld),
    .o_key_rdy  (key_rdy),
    .i_key_wrd  (key_wrd),
    .o_key_sub  (key_sub),
    .o_key_done (key_done),
    .o_wrd_sbox (wrd_out),
    .i_wrd_sbox (wrd_in),
    .o_busy     (busy)
  );

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rnd_done) begin
      if (q_rnd.size() == 0) chk("rnd_spurious", 1, 0);
      else chk("rnd_sub_sb", rnd_sub, q_rnd.pop_front());
    end
    if (key_done) begin
      if (q_key.size() == 0) chk("key_spurious", 1, 0);
      else chk("key_sub_sb", key_sub, q_key.pop_front());
    end
    if (rnd_done || key_done)
      chk("done_overlap", rnd_done & key_done, 0);
  end

  task automatic conflict(input string nm);
    bit kf;
`ifdef AES_SBOX_SCHED_RR_EN
    kf = (tb_last == 1'b0);
`else
    kf = 1'b1;
`endif
    rnd_vld = 1; rnd_text = TXT;
    key_vld = 1; key_wrd  = KW;
    q_rnd.push_back(SUB);
    q_key.push_back(KS);
    if (kf) begin
      tick();
      chk({nm, "_k_first"}, wrd_out, KW);
      key_vld = 0; key_wrd = 32'h0;
      tick();
      chk({nm, "_k_done"}, key_done, 1);
      chk({nm, "_r_held"}, rnd_rdy, 1);
      tick();
      chk({nm, "_r_acc"}, wrd_out, TXT[127:96]);
      rnd_vld = 0; rnd_text = '0;
      repeat (3) tick();
      chk({nm, "_r_early"}, rnd_done, 0);
      tick();
      chk({nm, "_r_done"}, rnd_done, 1);
      tb_last = 1'b0;
    end else begin
      tick();
      chk({nm, "_r_first"}, wrd_out, TXT[127:96]);
      rnd_vld = 0; rnd_text = '0;
      repeat (4) tick();
      chk({nm, "_r_done"}, rnd_done, 1);
      chk({nm, "_k_wait"}, key_done, 0);
      tick();
      chk({nm, "_k_acc"}, wrd_out, KW);
      key_vld = 0; key_wrd = 32'h0;
      tick();
      chk({nm, "_k_done"}, key_done, 1);
      tb_last = 1'b1;
    end
    tick();
  endtask

  initial begin
    rst = 1; rnd_vld = 1; key_vld = 1;
    rnd_text = TXT; key_wrd = KW;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_rnd_rdy", rnd_rdy, 0);
      chk("rst_key_rdy", key_rdy, 0);
      chk("rst_busy", busy, 0);
      chk("rst_outs", {rnd_sub, key_sub, wrd_out,
          rnd_done, key_done}, 0);
    end
    rst = 0; rnd_vld = 0; key_vld = 0;
    #1;
    chk("rel_rdy", {rnd_rdy, key_rdy}, 2'b11);
    chk("rel_busy", busy, 0);

    // plain round with input scrambled after accept
    rnd_vld = 1; rnd_text = TXT;
    q_rnd.push_back(SUB);
    tick();
    tb_last = 1'b0;
    rnd_vld = 0; rnd_text = 128'hdeadbeef_0badf00d_12345678_9abcdef0;
    chk("rnd_w0", wrd_out, TXT[127:96]);
    chk("rnd_busy", busy, 1);
    chk("rnd_krdy", key_rdy, 0);
    tick();
    chk("rnd_w1", wrd_out, TXT[95:64]);
    tick();
    chk("rnd_w2", wrd_out, TXT[63:32]);
    tick();
    chk("rnd_w3", wrd_out, TXT[31:0]);
    chk("rnd_nopart", rnd_sub, 0);
    chk("rnd_early", rnd_done, 0);
    tick();
    chk("rnd_done", rnd_done, 1);
    chk("rnd_sub", rnd_sub, SUB);
    chk("rnd_idle", {busy, rnd_rdy}, 2'b01);
    tick();
    chk("rnd_pulse", rnd_done, 0);

    key_vld = 1; key_wrd = KW;
    q_key.push_back(KS);
    tick();
    tb_last = 1'b1;
    key_vld = 0; key_wrd = 32'h0;
    chk("key_wrd", wrd_out, KW);
    tick();
    chk("key_done", key_done, 1);
    chk("key_sub", key_sub, KS);
    chk("key_rnd_hold", rnd_sub, SUB);
    tick();
    chk("key_pulse", key_done, 0);

    conflict("c1");

    // abort a round partway
    rnd_vld = 1; rnd_text = TXT;
    tick();
    rnd_vld = 0;
    tick();
    tick();
    rst = 1;
    tick();
    chk("abt_done", rnd_done, 0);
    chk("abt_sub", {rnd_sub, key_sub}, 0);
    chk("abt_busy", busy, 0);
    chk("abt_rdy", rnd_rdy, 0);
    rst = 0;
    tb_last = 1'b0;
    #1;
    chk("abt_rel", rnd_rdy, 1);
    tick();
    chk("abt_quiet", rnd_done, 0);

    conflict("c2");

    key_vld = 1; key_wrd = KW;
    q_key.push_back(KS);
    tick();
    tb_last = 1'b1;
    key_vld = 0;
    tick();
    chk("k2_done", key_done, 1);
    tick();

    conflict("c3");

    repeat (3) tick();
    chk("sb_empty", q_rnd.size() + q_key.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
